exec_cc_mreg: RTL and testbench
===============================

# exec_cc_mreg

Execute-stage back half of the Y86-64 pipeline, directly downstream of the 64-bit ALU wrapper (add/sub/and/xor). It derives ZF/SF/OF from the ALU operands and result, holds the condition-code register, evaluates the jXX/cmovXX condition, and captures the execute results into the E/M pipeline register with stall and bubble control. Its outputs feed the memory stage and the forwarding network.

## Interface
- N, 64, datapath width (ALU operand/result width)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- e_icode  in  4  icode of the instruction in E
- e_ifun  in  4  ifun (condition or ALU op) of the instruction in E
- e_stat  in  3  status of the instruction in E
- alu_ctrl  in  3  ALU op: 0 add, 1 sub (x-y), 2 and, 3 xor
- alu_x, alu_y  in  N  ALU operands as presented to the ALU
- alu_result  in  N  ALU result
- e_valA  in  N  valA passed through to M
- e_dstE, e_dstM  in  4  destination register IDs (0xF = none)
- m_exc, w_exc  in  1  exception (stat not AOK) present in M / W stage
- m_stall, m_bubble  in  1  E/M register hold / inject bubble
- e_cnd  out  1  condition result (combinational, current CC)
- e_dstE_fwd  out  4  dstE after cmov squash (combinational, for forwarding)
- cc_zf, cc_sf, cc_of  out  1  condition-code register
- m_icode, m_stat, m_dstE, m_dstM  out  4/3/4/4  registered
- m_valE, m_valA  out  N  registered
- m_cnd  out  1  registered

## Operation
- Flags from current ALU outputs: ZF = (alu_result==0); SF = alu_result[N-1]; OF: add = (x[N-1]==y[N-1]) && (r[N-1]!=x[N-1]); sub = (x[N-1]!=y[N-1]) && (r[N-1]!=x[N-1]); and/xor = 0; alu_ctrl 4–7 → all flags 0.
- set_cc = (e_icode==IOPQ 0x6) && !m_exc && !w_exc. When set, CC loads the flags at the clock edge; otherwise CC holds. CC update is independent of m_stall/m_bubble.
- e_cnd from registered CC by e_ifun: 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; 7–15 → 0.
- e_dstE_fwd = 0xF when e_icode==IRRMOVQ (0x2) and !e_cnd; else e_dstE.
- E/M register: m_bubble=1 → load bubble; else m_stall=1 → hold; else load {e_icode, e_stat, e_cnd, alu_result, e_valA, e_dstE_fwd, e_dstM}. Bubble dominates stall.
- Bubble value: icode 0x1 (nop), stat 1 (AOK), dstE=dstM=0xF, cnd 0, valE=valA=0.

## Timing
- Reset (async, rst_n low): ZF=1, SF=0, OF=0; M register = bubble value. Reset release: next rising edge behaves normally.
- CC: flags computed in cycle t are visible on cc_* and used by e_cnd in cycle t+1 (one-cycle latency); instruction setting CC does not see its own flags.
- M register: one-cycle latency E → M.
- OPq in E with m_exc or w_exc high: CC unchanged; M register still loads per stall/bubble rules.
- Reset asserted mid-stall or mid-bubble: reset value wins immediately.
- e_cnd and e_dstE_fwd are purely combinational from CC and E inputs; no path from alu_* to e_cnd.

## Structure
- Shared package y86_pkg: icode constants (INOP, IRRMOVQ, IOPQ, IJXX, …), stat codes (SAOK, SHLT, SADR, SINS), RNONE=0xF, ALU op codes, condition ifun codes, CC struct {zf, sf, of}, bubble constants.
- One sub-module: y86_cond (combinational ifun + CC → cnd), reusable by the branch-predict check.

## Test plan
- Reset: rst_n low → cc = Z1 S0 O0, m_icode=0x1, m_dstE=0xF, m_stat=1, m_valE=0.
- OPq add x=0x7FFF_FFFF_FFFF_FFFF, y=1, r=0x8000_0000_0000_0000 → next cycle cc Z0 S1 O1; following cmovl (ifun 2) → e_cnd=0, e_dstE_fwd=0xF, m_dstE=0xF.
- OPq sub x=5, y=5, r=0 → cc Z1 S0 O0; jXX ifun 3 (je) → e_cnd=1, m_cnd=1; ifun 6 (jg) → 0.
- OPq xor with m_exc=1 → CC unchanged from prior value; M register still captures the OPq (m_icode=0x6, m_valE=r).
- m_stall=1 for 3 cycles with changing E inputs → M outputs constant; m_stall=1 & m_bubble=1 → bubble value loaded.
- rst_n pulsed low during m_stall with CC = Z0 S1 O0 → immediate reset values on all outputs, normal capture on first edge after release.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 definitions used by the execute stage and by any
// block that evaluates conditions: instruction codes, status codes, the
// "no register" ID, ALU op encodings, condition ifun codes, the
// condition-code struct and the E/M bubble constants.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Register ID meaning "no destination"
  localparam logic [3:0] RNONE = 4'hF;

  // ALU operations
  localparam logic [2:0] ALUADD = 3'd0;
  localparam logic [2:0] ALUSUB = 3'd1;
  localparam logic [2:0] ALUAND = 3'd2;
  localparam logic [2:0] ALUXOR = 3'd3;

  // Condition ifun codes shared by jXX and cmovXX
  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Contents of an empty (bubbled) E/M slot
  localparam logic [3:0] BUB_ICODE = INOP;
  localparam logic [2:0] BUB_STAT  = SAOK;

endpackage

// File: rtl/y86_cond.sv
// y86_cond: combinational condition evaluator.
// Ports:
//   ifun - condition code field of a jXX / cmovXX instruction
//   cc   - condition-code flags {zf, sf, of}
//   cnd  - 1 when the condition holds; unused ifun values give 0
module y86_cond
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  cc_t        cc,
  output logic       cnd
);

  logic lt;
  assign lt = cc.sf ^ cc.of;  // signed "less than" after a compare

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | cc.zf;
      C_L:     cnd = lt;
      C_E:     cnd = cc.zf;
      C_NE:    cnd = ~cc.zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~cc.zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cc_mreg.sv
// exec_cc_mreg: back half of the Y86-64 execute stage.
// Derives ZF/SF/OF from the ALU operands/result, holds the condition-code
// register, evaluates the jXX/cmovXX condition against the stored flags,
// and captures execute results into the E/M pipeline register.
// Ports:
//   clk, rst_n                - clock, async active-low reset
//   e_icode/e_ifun/e_stat     - instruction in E
//   alu_ctrl/alu_x/alu_y/alu_result - ALU op, operands and result
//   e_valA, e_dstE, e_dstM    - values passed through to M
//   m_exc, w_exc              - exception in M / W, blocks CC update
//   m_stall, m_bubble         - E/M hold / bubble injection (bubble wins)
//   e_cnd, e_dstE_fwd         - combinational condition and squashed dstE
//   cc_zf, cc_sf, cc_of       - condition-code register
//   m_*                       - E/M pipeline register outputs
module exec_cc_mreg
  import y86_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [2:0]   e_stat,
  input  logic [2:0]   alu_ctrl,
  input  logic [N-1:0] alu_x,
  input  logic [N-1:0] alu_y,
  input  logic [N-1:0] alu_result,
  input  logic [N-1:0] e_valA,
  input  logic [3:0]   e_dstE,
  input  logic [3:0]   e_dstM,
  input  logic         m_exc,
  input  logic         w_exc,
  input  logic         m_stall,
  input  logic         m_bubble,
  output logic         e_cnd,
  output logic [3:0]   e_dstE_fwd,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic [3:0]   m_icode,
  output logic [2:0]   m_stat,
  output logic [3:0]   m_dstE,
  output logic [3:0]   m_dstM,
  output logic [N-1:0] m_valE,
  output logic [N-1:0] m_valA,
  output logic         m_cnd
);

  cc_t  cc;
  cc_t  flags;
  logic set_cc;

  logic x_sign, y_sign, r_sign;
  assign x_sign = alu_x[N-1];
  assign y_sign = alu_y[N-1];
  assign r_sign = alu_result[N-1];

  // Overflow: operands whose signs allow overflow, and a result whose sign
  // differs from x. For sub the operand signs must differ since y is negated.
  always_comb begin
    flags.zf = (alu_result == '0);
    flags.sf = r_sign;
    flags.of = 1'b0;
    case (alu_ctrl)
      ALUADD:  flags.of = (x_sign == y_sign) && (r_sign != x_sign);
      ALUSUB:  flags.of = (x_sign != y_sign) && (r_sign != x_sign);
      ALUAND,
      ALUXOR:  flags.of = 1'b0;
      default: flags    = '0;  // undefined ops clear every flag
    endcase
  end

  // A younger OPq must not modify CC once an older instruction has faulted.
  assign set_cc = (e_icode == IOPQ) && !m_exc && !w_exc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (set_cc) begin
      cc <= flags;
    end
  end

  assign cc_zf = cc.zf;
  assign cc_sf = cc.sf;
  assign cc_of = cc.of;

  // Condition reads only the stored CC, so an OPq never sees its own flags.
  y86_cond u_cond (
    .ifun (e_ifun),
    .cc   (cc),
    .cnd  (e_cnd)
  );

  // A cmov whose condition fails writes nothing.
  assign e_dstE_fwd = ((e_icode == IRRMOVQ) && !e_cnd) ? RNONE : e_dstE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_icode <= BUB_ICODE;
      m_stat  <= BUB_STAT;
      m_cnd   <= 1'b0;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= RNONE;
      m_dstM  <= RNONE;
    end else if (m_bubble) begin
      m_icode <= BUB_ICODE;
      m_stat  <= BUB_STAT;
      m_cnd   <= 1'b0;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= RNONE;
      m_dstM  <= RNONE;
    end else if (!m_stall) begin
      m_icode <= e_icode;
      m_stat  <= e_stat;
      m_cnd   <= e_cnd;
      m_valE  <= alu_result;
      m_valA  <= e_valA;
      m_dstE  <= e_dstE_fwd;
      m_dstM  <= e_dstM;
    end
  end

endmodule

// File: tb/tb_exec_cc_mreg.sv
// tb_exec_cc_mreg: directed and randomized checks of exec_cc_mreg against a
// behavioural model (flags from exact signed arithmetic, condition table,
// E/M slot model).
module tb_exec_cc_mreg;
  import y86_pkg::*;

  localparam int N = 64;

  logic         clk;
  logic         rst_n;
  logic [3:0]   e_icode, e_ifun;
  logic [2:0]   e_stat, alu_ctrl;
  logic [N-1:0] alu_x, alu_y, alu_result, e_valA;
  logic [3:0]   e_dstE, e_dstM;
  logic         m_exc, w_exc, m_stall, m_bubble;
  logic         e_cnd;
  logic [3:0]   e_dstE_fwd;
  logic         cc_zf, cc_sf, cc_of;
  logic [3:0]   m_icode, m_dstE, m_dstM;
  logic [2:0]   m_stat;
  logic [N-1:0] m_valE, m_valA;
  logic         m_cnd;

  exec_cc_mreg #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .e_icode    (e_icode),
    .e_ifun     (e_ifun),
    .e_stat     (e_stat),
    .alu_ctrl   (alu_ctrl),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result),
    .e_valA     (e_valA),
    .e_dstE     (e_dstE),
    .e_dstM     (e_dstM),
    .m_exc      (m_exc),
    .w_exc      (w_exc),
    .m_stall    (m_stall),
    .m_bubble   (m_bubble),
    .e_cnd      (e_cnd),
    .e_dstE_fwd (e_dstE_fwd),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of),
    .m_icode    (m_icode),
    .m_stat     (m_stat),
    .m_dstE     (m_dstE),
    .m_dstM     (m_dstM),
    .m_valE     (m_valE),
    .m_valA     (m_valA),
    .m_cnd      (m_cnd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  // Reference state
  logic         ref_zf, ref_sf, ref_of;
  logic [3:0]   ref_icode, ref_dstE, ref_dstM;
  logic [2:0]   ref_stat;
  logic [N-1:0] ref_valE, ref_valA;
  logic         ref_cnd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags from exact integer arithmetic: overflow means the true signed
  // result does not equal the N-bit result read as signed.
  function automatic logic [2:0] flags_ref(input logic [2:0] c, input logic [N-1:0] x,
                                           input logic [N-1:0] y, input logic [N-1:0] r);
    logic signed [N:0] t, rs;
    logic zf, sf, of;
    if (c > 3'd3) return 3'b000;
    rs = $signed(r);
    t  = '0;
    if (c == 3'd0) t = $signed(x) + $signed(y);
    if (c == 3'd1) t = $signed(x) - $signed(y);
    zf = (r == '0);
    sf = (rs < 0);
    of = (c <= 3'd1) && (t != rs);
    return {zf, sf, of};
  endfunction

  function automatic logic cond_ref(input logic [3:0] f);
    logic less;
    less = (ref_sf != ref_of);
    case (f)
      4'd0: return 1'b1;
      4'd1: return less || ref_zf;
      4'd2: return less;
      4'd3: return ref_zf;
      4'd4: return !ref_zf;
      4'd5: return !less;
      4'd6: return !less && !ref_zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [N-1:0] alu_ref(input logic [2:0] c, input logic [N-1:0] x,
                                           input logic [N-1:0] y);
    case (c)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x ^ y;
      default: return ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [N-1:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 64'h0;
      1: return 64'h1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic ref_reset();
    {ref_zf, ref_sf, ref_of} = 3'b100;
    ref_icode = 4'h1; ref_stat = 3'd1; ref_cnd = 1'b0;
    ref_valE = '0; ref_valA = '0; ref_dstE = 4'hF; ref_dstM = 4'hF;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "_cc_zf"},   cc_zf,   ref_zf);
    check({pfx, "_cc_sf"},   cc_sf,   ref_sf);
    check({pfx, "_cc_of"},   cc_of,   ref_of);
    check({pfx, "_m_icode"}, m_icode, ref_icode);
    check({pfx, "_m_stat"},  m_stat,  ref_stat);
    check({pfx, "_m_cnd"},   m_cnd,   ref_cnd);
    check({pfx, "_m_valE"},  m_valE,  ref_valE);
    check({pfx, "_m_valA"},  m_valA,  ref_valA);
    check({pfx, "_m_dstE"},  m_dstE,  ref_dstE);
    check({pfx, "_m_dstM"},  m_dstM,  ref_dstM);
  endtask

  // Called at a falling edge; asserts reset mid-cycle, checks the immediate
  // reset values, releases on the next falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    ref_reset();
    check("rst_cc_zf",   cc_zf,   1'b1);
    check("rst_cc_sf",   cc_sf,   1'b0);
    check("rst_cc_of",   cc_of,   1'b0);
    check("rst_m_icode", m_icode, 4'h1);
    check("rst_m_stat",  m_stat,  3'd1);
    check("rst_m_dstE",  m_dstE,  4'hF);
    check("rst_m_dstM",  m_dstM,  4'hF);
    check("rst_m_valE",  m_valE,  64'h0);
    check("rst_m_valA",  m_valA,  64'h0);
    check("rst_m_cnd",   m_cnd,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn %0d reset pulse", n_txn);
    n_txn++;
  endtask

  // One E-stage cycle. Called at a falling edge, returns at the next one.
  task automatic apply(input logic [3:0] icode, input logic [3:0] ifun, input logic [2:0] stat,
                       input logic [2:0] ctrl, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [N-1:0] r, input logic [N-1:0] va,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic mx, input logic wx, input logic st, input logic bb);
    logic       exp_cnd;
    logic [3:0] exp_fwd;
    logic [2:0] f;
    e_icode = icode; e_ifun = ifun; e_stat = stat; alu_ctrl = ctrl;
    alu_x = x; alu_y = y; alu_result = r; e_valA = va;
    e_dstE = de; e_dstM = dm; m_exc = mx; w_exc = wx; m_stall = st; m_bubble = bb;
    #1;
    exp_cnd = cond_ref(ifun);
    exp_fwd = (icode == 4'h2 && !exp_cnd) ? 4'hF : de;
    check("e_cnd", e_cnd, exp_cnd);
    check("e_dstE_fwd", e_dstE_fwd, exp_fwd);
    @(posedge clk);
    if (icode == 4'h6 && !mx && !wx) begin
      f = flags_ref(ctrl, x, y, r);
      {ref_zf, ref_sf, ref_of} = f;
    end
    if (bb) begin
      ref_icode = 4'h1; ref_stat = 3'd1; ref_cnd = 1'b0;
      ref_valE = '0; ref_valA = '0; ref_dstE = 4'hF; ref_dstM = 4'hF;
    end else if (!st) begin
      ref_icode = icode; ref_stat = stat; ref_cnd = exp_cnd;
      ref_valE = r; ref_valA = va; ref_dstE = exp_fwd; ref_dstM = dm;
    end
    #1;
    check_regs("m");
    $display("txn %0d icode=%h ifun=%h ctrl=%0d r=%h stall=%b bub=%b exc=%b%b cnd=%b cc=%b%b%b m_icode=%h m_dstE=%h",
             n_txn, icode, ifun, ctrl, r, st, bb, mx, wx, exp_cnd, ref_zf, ref_sf, ref_of,
             m_icode, m_dstE);
    n_txn++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    e_icode = 4'h1; e_ifun = 4'h0; e_stat = 3'd1; alu_ctrl = 3'd0;
    alu_x = '0; alu_y = '0; alu_result = '0; e_valA = '0;
    e_dstE = 4'hF; e_dstM = 4'hF;
    m_exc = 1'b0; w_exc = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
    ref_reset();
    @(negedge clk);
    do_reset();

    // Signed overflow on add, then cmovl sees Z0 S1 O1 -> not taken
    apply(4'h6, 4'h0, 3'd1, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000,
          64'h0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("add_ovf_zf", cc_zf, 1'b0);
    check("add_ovf_sf", cc_sf, 1'b1);
    check("add_ovf_of", cc_of, 1'b1);
    apply(4'h2, 4'h2, 3'd1, 3'd0, 64'h55, 64'h0, 64'h55, 64'h55, 4'h4, 4'hF,
          1'b0, 1'b0, 1'b0, 1'b0);
    check("cmovl_m_dstE", m_dstE, 4'hF);

    // Equal compare, then je taken, jg not taken
    apply(4'h6, 4'h1, 3'd1, 3'd1, 64'd5, 64'd5, 64'd0, 64'h0, 4'h2, 4'hF,
          1'b0, 1'b0, 1'b0, 1'b0);
    check("sub_eq_zf", cc_zf, 1'b1);
    check("sub_eq_of", cc_of, 1'b0);
    apply(4'h7, 4'h3, 3'd1, 3'd0, 64'h0, 64'h0, 64'h0, 64'h100, 4'hF, 4'hF,
          1'b0, 1'b0, 1'b0, 1'b0);
    check("je_m_cnd", m_cnd, 1'b1);
    apply(4'h7, 4'h6, 3'd1, 3'd0, 64'h0, 64'h0, 64'h0, 64'h200, 4'hF, 4'hF,
          1'b0, 1'b0, 1'b0, 1'b0);
    check("jg_m_cnd", m_cnd, 1'b0);

    // xor under an older exception: CC frozen, M still captures
    apply(4'h6, 4'h3, 3'd1, 3'd3, 64'hF0, 64'h0F, 64'hFF, 64'h0, 4'h5, 4'hF,
          1'b1, 1'b0, 1'b0, 1'b0);
    check("exc_cc_zf", cc_zf, 1'b1);
    check("exc_m_icode", m_icode, 4'h6);
    check("exc_m_valE", m_valE, 64'hFF);

    // Hold for three cycles with changing E inputs, then stall+bubble
    apply(4'h2, 4'h0, 3'd1, 3'd0, 64'h1234, 64'h0, 64'h1234, 64'h1234, 4'h7, 4'hF,
          1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(4'h6, 4'($urandom_range(0, 3)), 3'd1, 3'd0, pick_op(), 64'h0, {$urandom, $urandom},
            {$urandom, $urandom}, 4'($urandom), 4'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
      check("stall_m_valE", m_valE, 64'h1234);
    end
    apply(4'h6, 4'h0, 3'd2, 3'd0, 64'h1, 64'h1, 64'h2, 64'h9, 4'h1, 4'h2,
          1'b0, 1'b1, 1'b1, 1'b1);
    check("stbub_m_icode", m_icode, 4'h1);

    // CC = Z0 S1 O0, then reset in the middle of a stall
    apply(4'h6, 4'h1, 3'd1, 3'd1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 4'h6, 4'hF,
          1'b0, 1'b0, 1'b0, 1'b0);
    check("neg_cc_sf", cc_sf, 1'b1);
    apply(4'h1, 4'h0, 3'd1, 3'd0, 64'h0, 64'h0, 64'h77, 64'h0, 4'hF, 4'hF,
          1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    apply(4'h3, 4'h0, 3'd1, 3'd0, 64'h0, 64'h42, 64'h42, 64'h0, 4'h8, 4'hF,
          1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_m_valE", m_valE, 64'h42);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      logic [3:0]   ic;
      logic [2:0]   c;
      logic [N-1:0] x, y;
      case ($urandom_range(0, 5))
        0, 1, 2: ic = 4'h6;
        3:       ic = 4'h2;
        4:       ic = 4'h7;
        default: ic = 4'($urandom);
      endcase
      c = 3'($urandom_range(0, 7));
      if (c > 3'd3 && $urandom_range(0, 1) == 0) c = 3'($urandom_range(0, 3));
      x = pick_op();
      y = ($urandom_range(0, 4) == 0) ? x : pick_op();
      apply(ic, 4'($urandom_range(0, 9)), 3'($urandom_range(1, 4)), c, x, y, alu_ref(c, x, y),
            {$urandom, $urandom}, 4'($urandom), 4'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
